// File: rtl/ixu_sc_issue_queue.sv
// Collapsing, age-ordered issue queue for the single-cycle pipe.
// Slot 0 holds the oldest entry. The lowest-index ready entry issues, and younger entries shift down one slot.
module ixu_sc_issue_queue #(
    parameter int DEPTH    = 8,
    parameter int WK_PORTS = 2
) (
    input  logic                  core_clock_i,
    input  logic                  core_reset_i,
    input  logic                  core_flush_i,
    input  logic [17:0]           enq_data_i,
    input  logic                  enq_rs1_rdy_i,
    input  logic                  enq_rs2_rdy_i,
    input  logic                  enq_valid_i,
    output logic                  enq_ready_o,
    input  logic [6*WK_PORTS-1:0] wk_dest_i,
    input  logic [WK_PORTS-1:0]   wk_valid_i,
    output logic [17:0]           data_o,
    output logic                  valid_o,
    output logic [$clog2(DEPTH):0] occupancy_o
);
    localparam int IW = $clog2(DEPTH);
    localparam int OW = IW + 1;
    localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);

    logic [DEPTH-1:0] vld_q, rs1_rdy_q, rs2_rdy_q;
    logic [DEPTH-1:0] vld_d, rs1_rdy_d, rs2_rdy_d;
    logic [17:0]      pay_q [DEPTH];
    logic [17:0]      pay_d [DEPTH];
    logic [DEPTH-1:0] ready_vec, rs1_wk, rs2_wk;
    logic [IW-1:0]    sel;
    logic             issue, do_enq;
    logic             enq_rs1_rdy, enq_rs2_rdy;
    logic [OW-1:0]    occ, enq_slot;
    int               src;

    // Physical register 0 is never a wakeup target; entries sourcing it are marked ready at dispatch.
    function automatic logic woken(input logic [5:0] preg,
                                   input logic [6*WK_PORTS-1:0] dests,
                                   input logic [WK_PORTS-1:0] vlds);
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < WK_PORTS; p++)
            if (vlds[p] && (dests[6*p +: 6] == preg) && (preg != 6'd0))
                hit = 1'b1;
        return hit;
    endfunction

    always_comb begin
        ready_vec = '0;
        occ       = '0;
        issue     = 1'b0;
        sel       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready_vec[i] = vld_q[i] & rs1_rdy_q[i] & rs2_rdy_q[i];
            occ          = occ + OW'(vld_q[i]);
        end
        for (int i = DEPTH - 1; i >= 0; i--)
            if (ready_vec[i]) begin
                issue = 1'b1;
                sel   = IW'(i);
            end
    end

    assign enq_ready_o = (occ < DEPTH_C);
    assign valid_o     = issue;
    assign data_o      = issue ? pay_q[sel] : 18'd0;
    assign occupancy_o = occ;
    assign do_enq      = enq_valid_i & enq_ready_o & ~core_flush_i;
    assign enq_slot    = occ - OW'(issue);

    always_comb begin
        rs1_wk = '0;
        rs2_wk = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rs1_wk[i] = rs1_rdy_q[i] | woken(pay_q[i][11:6], wk_dest_i, wk_valid_i);
            rs2_wk[i] = rs2_rdy_q[i] | woken(pay_q[i][17:12], wk_dest_i, wk_valid_i);
        end
        enq_rs1_rdy = enq_rs1_rdy_i | (enq_data_i[11:6] == 6'd0)
                    | woken(enq_data_i[11:6], wk_dest_i, wk_valid_i);
        enq_rs2_rdy = enq_rs2_rdy_i | (enq_data_i[17:12] == 6'd0)
                    | woken(enq_data_i[17:12], wk_dest_i, wk_valid_i);
    end

    // Slots at or above the issuing one pull from their younger neighbour; the new entry lands after compaction.
    always_comb begin
        vld_d     = '0;
        rs1_rdy_d = '0;
        rs2_rdy_d = '0;
        src       = 0;
        for (int i = 0; i < DEPTH; i++)
            pay_d[i] = pay_q[i];
        for (int i = 0; i < DEPTH; i++) begin
            src = (issue && (i >= int'(sel))) ? i + 1 : i;
            if (src < DEPTH) begin
                vld_d[i]     = vld_q[src % DEPTH];
                rs1_rdy_d[i] = rs1_wk[src % DEPTH];
                rs2_rdy_d[i] = rs2_wk[src % DEPTH];
                pay_d[i]     = pay_q[src % DEPTH];
            end
            if (do_enq && (i == int'(enq_slot))) begin
                vld_d[i]     = 1'b1;
                rs1_rdy_d[i] = enq_rs1_rdy;
                rs2_rdy_d[i] = enq_rs2_rdy;
                pay_d[i]     = enq_data_i;
            end
        end
        if (core_flush_i)
            vld_d = '0;
    end

    always_ff @(posedge core_clock_i) begin
        if (core_reset_i) begin
            vld_q     <= '0;
            rs1_rdy_q <= '0;
            rs2_rdy_q <= '0;
        end else begin
            vld_q     <= vld_d;
            rs1_rdy_q <= rs1_rdy_d;
            rs2_rdy_q <= rs2_rdy_d;
        end
    end

    always_ff @(posedge core_clock_i) begin
        for (int i = 0; i < DEPTH; i++)
            pay_q[i] <= pay_d[i];
    end

endmodule

// File: tb/tb_ixu_sc_issue_queue.sv
// Directed and random stimulus against a queue-based reference model.
// Predicted issues are pushed to a scoreboard and popped when the DUT raises valid_o.
module tb_ixu_sc_issue_queue;
    localparam int DEPTH    = 8;
    localparam int WK_PORTS = 2;

    logic                  core_clock_i = 1'b0;
    logic                  core_reset_i = 1'b0;
    logic                  core_flush_i = 1'b0;
    logic [17:0]           enq_data_i = '0;
    logic                  enq_rs1_rdy_i = 1'b0;
    logic                  enq_rs2_rdy_i = 1'b0;
    logic                  enq_valid_i = 1'b0;
    logic                  enq_ready_o;
    logic [6*WK_PORTS-1:0] wk_dest_i = '0;
    logic [WK_PORTS-1:0]   wk_valid_i = '0;
    logic [17:0]           data_o;
    logic                  valid_o;
    logic [3:0]            occupancy_o;

    always #5 core_clock_i = ~core_clock_i;

    ixu_sc_issue_queue #(.DEPTH(DEPTH), .WK_PORTS(WK_PORTS)) dut (
        .core_clock_i (core_clock_i),
        .core_reset_i (core_reset_i),
        .core_flush_i (core_flush_i),
        .enq_data_i   (enq_data_i),
        .enq_rs1_rdy_i(enq_rs1_rdy_i),
        .enq_rs2_rdy_i(enq_rs2_rdy_i),
        .enq_valid_i  (enq_valid_i),
        .enq_ready_o  (enq_ready_o),
        .wk_dest_i    (wk_dest_i),
        .wk_valid_i   (wk_valid_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .occupancy_o  (occupancy_o)
    );

    typedef struct {
        logic [17:0] pay;
        bit          r1;
        bit          r2;
    } ent_t;

    ent_t        modelQ[$];
    logic [17:0] scoreBoard[$];
    int          checks = 0;
    int          errors = 0;

    function automatic logic [17:0] mk(input int rob, input int rs1, input int rs2);
        return {6'(rs2), 6'(rs1), 6'(rob)};
    endfunction

    function automatic bit modelWake(input logic [5:0] preg, input logic [11:0] wd, input logic [1:0] wv);
        return (preg != 6'd0) && ((wv[0] && (wd[5:0] == preg)) || (wv[1] && (wd[11:6] == preg)));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        bit          expValid;
        logic [17:0] expData;
        expValid = 1'b0;
        expData  = '0;
        for (int i = 0; i < modelQ.size(); i++)
            if (!expValid && modelQ[i].r1 && modelQ[i].r2) begin
                expValid = 1'b1;
                expData  = modelQ[i].pay;
            end
        if (expValid)
            scoreBoard.push_back(expData);
        check("valid", 32'(valid_o), 32'(expValid));
        check("occupancy", 32'(occupancy_o), modelQ.size());
        check("enq_ready", 32'(enq_ready_o), 32'(modelQ.size() < DEPTH));
        if (valid_o === 1'b1) begin
            checks++;
            assert (scoreBoard.size() > 0) else begin
                errors++;
                $error("[TB] FAIL sb_empty: observed issue %0h expected none", data_o);
            end
            if (scoreBoard.size() > 0)
                check("issue_data", 32'(data_o), 32'(scoreBoard.pop_front()));
        end else begin
            check("idle_data", 32'(data_o), 32'd0);
        end
        scoreBoard.delete();
    endtask

    task automatic modelUpdate(input bit rst, input bit fl, input bit ev, input logic [17:0] d,
                               input bit r1, input bit r2, input logic [11:0] wd, input logic [1:0] wv);
        int   idx;
        bit   canEnq;
        ent_t e;
        idx = -1;
        if (rst || fl) begin
            modelQ.delete();
        end else begin
            for (int i = 0; i < modelQ.size(); i++)
                if (idx < 0 && modelQ[i].r1 && modelQ[i].r2)
                    idx = i;
            canEnq = (modelQ.size() < DEPTH);
            for (int i = 0; i < modelQ.size(); i++) begin
                modelQ[i].r1 = modelQ[i].r1 | modelWake(modelQ[i].pay[11:6], wd, wv);
                modelQ[i].r2 = modelQ[i].r2 | modelWake(modelQ[i].pay[17:12], wd, wv);
            end
            if (idx >= 0)
                modelQ.delete(idx);
            if (ev && canEnq) begin
                e.pay = d;
                e.r1  = r1 | (d[11:6] == 6'd0) | modelWake(d[11:6], wd, wv);
                e.r2  = r2 | (d[17:12] == 6'd0) | modelWake(d[17:12], wd, wv);
                modelQ.push_back(e);
            end
        end
    endtask

    // Drive on the falling edge, compare just after, then advance the model at the rising edge.
    task automatic applyStimulus(input bit rst, input bit fl, input bit ev, input logic [17:0] d,
                                 input bit r1, input bit r2, input logic [11:0] wd, input logic [1:0] wv,
                                 input bit doCheck);
        @(negedge core_clock_i);
        core_reset_i  = rst;
        core_flush_i  = fl;
        enq_valid_i   = ev;
        enq_data_i    = d;
        enq_rs1_rdy_i = r1;
        enq_rs2_rdy_i = r2;
        wk_dest_i     = wd;
        wk_valid_i    = wv;
        #1;
        if (doCheck)
            checkOutput();
        @(posedge core_clock_i);
        modelUpdate(rst, fl, ev, d, r1, r2, wd, wv);
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, '0, 0, 0, '0, '0, 1);
    endtask

    task automatic enq(input logic [17:0] d, input bit r1, input bit r2);
        applyStimulus(0, 0, 1, d, r1, r2, '0, '0, 1);
    endtask

    task automatic wake(input int a, input int b, input logic [1:0] wv);
        applyStimulus(0, 0, 0, '0, 0, 0, {6'(b), 6'(a)}, wv, 1);
    endtask

    initial begin
        applyStimulus(1, 0, 0, '0, 0, 0, '0, '0, 0);
        applyStimulus(1, 0, 0, '0, 0, 0, '0, '0, 1);
        idle();

        enq(mk(5, 3, 0), 1, 0);
        #2;
        check("r030_valid", 32'(valid_o), 32'd1);
        check("r030_rob", 32'(data_o[5:0]), 32'd5);
        check("r030_occ1", 32'(occupancy_o), 32'd1);
        idle();
        idle();

        enq(mk(6, 0, 0), 1, 1);
        enq(mk(7, 0, 0), 1, 1);
        #2;
        check("r024_occ", 32'(occupancy_o), 32'd1);
        check("r024_rob", 32'(data_o[5:0]), 32'd7);
        idle();

        enq(mk(1, 9, 0), 0, 0);
        enq(mk(2, 0, 0), 0, 0);
        #2;
        check("r031_first", 32'(data_o[5:0]), 32'd2);
        idle();
        wake(9, 0, 2'b01);
        #2;
        check("r031_second", 32'(data_o[5:0]), 32'd1);
        idle();

        for (int i = 0; i < DEPTH; i++)
            enq(mk(16 + i, 32 + i, 0), 0, 0);
        applyStimulus(0, 0, 1, mk(30, 0, 0), 1, 1, '0, '0, 1);
        #2;
        check("r032_full_occ", 32'(occupancy_o), 32'd8);
        check("r032_full_rdy", 32'(enq_ready_o), 32'd0);
        wake(32, 0, 2'b01);
        #2;
        check("r032_oldest", 32'(data_o[5:0]), 32'd16);
        wake(33, 34, 2'b11);
        wake(35, 36, 2'b11);
        wake(37, 38, 2'b11);
        wake(0, 39, 2'b10);
        repeat (8) idle();

        applyStimulus(0, 0, 1, mk(3, 0, 7), 1, 0, {6'd7, 6'd0}, 2'b10, 1);
        #2;
        check("r033_bypass", 32'(data_o[5:0]), 32'd3);
        idle();

        for (int i = 0; i < 5; i++)
            enq(mk(40 + i, 50 + i, 0), 0, 0);
        applyStimulus(0, 1, 1, mk(9, 0, 0), 1, 1, '0, '0, 1);
        #2;
        check("r034_occ", 32'(occupancy_o), 32'd0);
        check("r034_valid", 32'(valid_o), 32'd0);
        idle();

        enq(mk(11, 0, 0), 1, 1);
        enq(mk(12, 5, 0), 0, 0);
        enq(mk(13, 0, 0), 1, 1);
        applyStimulus(1, 0, 1, mk(14, 0, 0), 1, 1, {6'd5, 6'd5}, 2'b11, 1);
        #2;
        check("r035_valid", 32'(valid_o), 32'd0);
        check("r035_data", 32'(data_o), 32'd0);
        check("r035_occ", 32'(occupancy_o), 32'd0);
        check("r035_rdy", 32'(enq_ready_o), 32'd1);
        idle();

        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0,
                          $urandom_range(0, 3) != 0,
                          mk($urandom_range(0, 63), $urandom_range(0, 7), $urandom_range(0, 7)),
                          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                          {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))},
                          2'($urandom_range(0, 3)), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
